// File: rtl/pll_rst_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_rst_ctrl_if
// Groups the lock supervisor's control inputs and status outputs so the
// sequencer and its driver (SoC glue or a bench) connect through one bundle.
//   pll_lock       PLL extlock, asynchronous to clk
//   sw_rst_req     single-cycle software reset request (clk domain)
//   cnt_clr        single-cycle clear of lock_loss_cnt (clk domain)
//   sys_rst_n      registered active-low system reset
//   lock_sync      synchronised lock, last synchroniser stage
//   fsm_state      00 WAIT_LOCK, 01 STABLE, 10 HOLD, 11 RUN
//   lock_loss_cnt  saturating count of lock drops
// master: drives the requests and observes status; slave: the sequencer.
// -----------------------------------------------------------------------------
interface pll_rst_ctrl_if;
    logic       pll_lock;
    logic       sw_rst_req;
    logic       cnt_clr;
    logic       sys_rst_n;
    logic       lock_sync;
    logic [1:0] fsm_state;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock, sw_rst_req, cnt_clr,
        input  sys_rst_n, lock_sync, fsm_state, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, sw_rst_req, cnt_clr,
        output sys_rst_n, lock_sync, fsm_state, lock_loss_cnt
    );
endinterface

// File: rtl/pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// pll_rst_ctrl
// Lock supervisor and reset sequencer running on the free-running board clock
// (the PLL refclk net). Synchronises the PLL extlock, requires it to stay high
// for LOCK_STABLE_CYCLES, then holds the system reset low for RST_HOLD_CYCLES
// before releasing it. Lock drops are counted (saturating at 255) and software
// may re-run the hold phase while running.
// Ports:
//   clk    in  free-running 50 MHz board clock
//   rst_n  in  asynchronous active-low board reset
//   bus    slave modport of pll_rst_ctrl_if (pll_lock, sw_rst_req, cnt_clr in;
//          sys_rst_n, lock_sync, fsm_state, lock_loss_cnt out)
// -----------------------------------------------------------------------------
module pll_rst_ctrl #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pll_rst_ctrl_if.slave  bus
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    localparam logic [1:0] ST_WAIT   = 2'b00;
    localparam logic [1:0] ST_STABLE = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;
    localparam logic [1:0] ST_RUN    = 2'b11;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   lock_s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sys_rst_n_q;
    logic             sys_rst_n_d;
    logic [7:0]       loss_q;
    logic [7:0]       loss_d;
    logic             loss_evt;

    // Shift pll_lock in at bit 0; the top bit is the synchronised lock.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss is tested first so it beats a same-edge sw request.
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (bus.sw_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Any exit to WAIT_LOCK from a non-waiting state is a lock-loss event.
    assign loss_evt = (state_q != ST_WAIT) && !lock_s;

    always_comb begin
        loss_d = loss_q;
        if (bus.cnt_clr) begin
            loss_d = 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    // Reset output is decoded from the next state and registered, so it moves
    // on the same edge as the state and never glitches.
    assign sys_rst_n_d = (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            loss_q      <= 8'd0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            loss_q      <= loss_d;
        end
    end

    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.lock_sync     = lock_s;
    assign bus.fsm_state     = state_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_ctrl
// Directed scenarios plus a randomized phase for pll_rst_ctrl with
// SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4. A timestamp-based
// model (edge at which the stable window or a software hold began) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_pll_rst_ctrl;

    localparam int S = 2;
    localparam int L = 8;
    localparam int H = 4;

    logic clk;
    logic rst_n;

    pll_rst_ctrl_if bus ();

    pll_rst_ctrl #(
        .SYNC_STAGES       (S),
        .LOCK_STABLE_CYCLES(L),
        .RST_HOLD_CYCLES   (H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int n_edge     = 0;   // edges since reset release
    int seq_start  = -1;  // edge after which the stable window began
    int hold_start = -1;  // edge after which a software-requested hold began
    int loss_m     = 0;
    bit samp_q[$];        // pll_lock as sampled at each edge, newest last

    function automatic int state_at(input int m);
        int d;
        if (seq_start < 0) return 0;
        if (hold_start >= 0) begin
            d = m - hold_start;
            return (d < H) ? 2 : 3;
        end
        d = m - seq_start;
        if (d < L)     return 1;
        if (d < L + H) return 2;
        return 3;
    endfunction

    // Value of pll_lock sampled k edges before the newest sample.
    function automatic bit lsamp(input int k);
        if (samp_q.size() > k) return samp_q[samp_q.size() - 1 - k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        n_edge     = 0;
        seq_start  = -1;
        hold_start = -1;
        loss_m     = 0;
        samp_q.delete();
    endtask

    task automatic model_step();
        bit ls;
        int prev;
        n_edge++;
        ls   = lsamp(S - 1);       // lock seen by the FSM before this edge
        prev = state_at(n_edge - 1);
        if (prev == 0) begin
            if (ls) begin
                seq_start  = n_edge;
                hold_start = -1;
            end
        end else if (!ls) begin
            seq_start  = -1;
            hold_start = -1;
            if (loss_m < 255) loss_m++;
        end else if (prev == 3 && bus.sw_rst_req) begin
            hold_start = n_edge;
        end
        if (bus.cnt_clr) loss_m = 0;
        samp_q.push_back(bus.pll_lock);
        if (samp_q.size() > 8) void'(samp_q.pop_front());
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit chk_en = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int es;
                es = state_at(n_edge);
                chk("sys_rst_n", {31'd0, bus.sys_rst_n}, (es == 3) ? 32'd1 : 32'd0);
                chk("fsm_state", {30'd0, bus.fsm_state}, es);
                chk("lock_sync", {31'd0, bus.lock_sync}, {31'd0, lsamp(S - 1)});
                chk("lock_loss_cnt", {24'd0, bus.lock_loss_cnt}, loss_m);
            end
        end
    end

    // ---------------- helpers ----------------
    logic [1:0] st_log [0:63];
    logic       ls_log [0:63];
    logic [7:0] lc_log [0:63];

    // Returns the negedge index (1 = just after the first edge) at which
    // sys_rst_n is seen high, or 0 if it never rises within budget.
    task automatic watch(output int k);
        k = 0;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            st_log[i] = bus.fsm_state;
            ls_log[i] = bus.lock_sync;
            lc_log[i] = bus.lock_loss_cnt;
            if (bus.sys_rst_n === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.fsm_state === s) break;
        end
        chk(name, {30'd0, bus.fsm_state}, {30'd0, s});
    endtask

    task automatic goto_run();
        int k;
        bus.pll_lock = 1'b1;
        watch(k);
        chk("reach_run", {31'd0, bus.sys_rst_n}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.cnt_clr    = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_sys_rst_n", {31'd0, bus.sys_rst_n}, 32'd0);
        chk("rst_fsm_state", {30'd0, bus.fsm_state}, 32'd0);
        chk("rst_lock_sync", {31'd0, bus.lock_sync}, 32'd0);
        chk("rst_loss_cnt", {24'd0, bus.lock_loss_cnt}, 32'd0);

        // T1 power-up: lock raised so the first edge after release samples it.
        rst_n        = 1'b1;
        bus.pll_lock = 1'b1;
        watch(k);
        chk("T1_latency", k - 1, 32'd14);
        chk("T1_sync_k1", {31'd0, ls_log[1]}, 32'd0);
        chk("T1_sync_k2", {31'd0, ls_log[2]}, 32'd1);
        chk("T1_wait_k2", {30'd0, st_log[2]}, 32'd0);
        chk("T1_stable_k3", {30'd0, st_log[3]}, 32'd1);
        chk("T1_stable_k10", {30'd0, st_log[10]}, 32'd1);
        chk("T1_hold_k11", {30'd0, st_log[11]}, 32'd2);
        chk("T1_hold_k14", {30'd0, st_log[14]}, 32'd2);

        // T2 lock bounce: one drop from RUN, then a 2-cycle drop in STABLE.
        bus.pll_lock = 1'b0;
        wait_state("T2_to_wait", 2'b00, 10);
        chk("T2_loss1", {24'd0, bus.lock_loss_cnt}, 32'd1);
        bus.pll_lock = 1'b1;
        wait_state("T2_to_stable", 2'b01, 10);
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        bus.pll_lock = 1'b1;
        watch(k);
        chk("T2_relatency", k - 1, 32'd14);
        chk("T2_wait_k1", {30'd0, st_log[1]}, 32'd0);
        chk("T2_loss2", {24'd0, lc_log[1]}, 32'd2);
        chk("T2_restable_k3", {30'd0, st_log[3]}, 32'd1);

        // T3 software reset from RUN.
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        chk("T3_rst_low", {31'd0, bus.sys_rst_n}, 32'd0);
        chk("T3_hold", {30'd0, bus.fsm_state}, 32'd2);
        watch(k);
        chk("T3_hold_len", k, 32'd4);
        chk("T3_loss_same", {24'd0, bus.lock_loss_cnt}, 32'd2);

        // T4 collision: sw request on the edge the FSM first sees lock_s=0.
        bus.pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        chk("T4_state_wait", {30'd0, bus.fsm_state}, 32'd0);
        chk("T4_loss3", {24'd0, bus.lock_loss_cnt}, 32'd3);
        @(negedge clk);
        chk("T4_stays_wait", {30'd0, bus.fsm_state}, 32'd0);

        // T5 saturation, then clear on an increment edge.
        for (int i = 0; i < 300; i++) begin
            goto_run();
            bus.pll_lock = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("T5_saturated", {24'd0, bus.lock_loss_cnt}, 32'd255);
        goto_run();
        bus.pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        chk("T5_clear_wins", {24'd0, bus.lock_loss_cnt}, 32'd0);
        chk("T5_clear_state", {30'd0, bus.fsm_state}, 32'd0);

        // T6 asynchronous reset in the middle of HOLD.
        bus.pll_lock = 1'b1;
        wait_state("T6_reach_hold", 2'b10, 40);
        #3;
        rst_n = 1'b0;
        #1;
        chk("T6_sys_rst_n", {31'd0, bus.sys_rst_n}, 32'd0);
        chk("T6_fsm_state", {30'd0, bus.fsm_state}, 32'd0);
        chk("T6_lock_sync", {31'd0, bus.lock_sync}, 32'd0);
        chk("T6_loss_cnt", {24'd0, bus.lock_loss_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(k);
        chk("T6_relatency", k - 1, 32'd14);

        // Randomized phase: long lock runs, sporadic requests and resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) bus.pll_lock = ~bus.pll_lock;
            bus.sw_rst_req = ($urandom_range(0, 15) == 0);
            bus.cnt_clr    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        bus.cnt_clr    = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
